cpu_run_monitor: RTL
====================

# cpu_run_monitor

Synthesizable run-control and end-of-program detector for the single-cycle MIPS CPU. It replaces the fixed-delay bench sequence: it generates the CPU reset pulse, counts cycles and retired instructions, and stops the run. A run ends on an exit syscall, on a retire at a configured halt PC, on a retire-stall watchdog, or on a cycle-limit timeout. It sits beside the CPU, fed from the writeback/PC path, and drives the CPU reset and halt inputs plus bench- and FPGA-visible status.

## Interface
- PC_WIDTH, 32: width of `pc`.
- CNT_WIDTH, 32: width of cycle and retire counters.
- RESET_CYCLES, 2: cycles `cpu_reset` is held after monitor reset release or `restart`; minimum 1.
- MAX_CYCLES, 1000: RUN-cycle limit before TIMEOUT; 0 disables.
- STALL_LIMIT, 64: consecutive RUN cycles without a retire before STALL; 0 disables.
- HALT_PC, 32'h0000_1FFC: halt address.
- HALT_PC_EN, 0: 1 enables halt-PC detection.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- restart  input  1  synchronous pulse; re-enters HOLD from any state.
- retire_valid  input  1  one instruction retires this cycle.
- pc  input  PC_WIDTH  PC of the retiring instruction.
- instr  input  32  retiring instruction word.
- reg_v0  input  32  $v0 value read at retire.
- reg_a0  input  32  $a0 value read at retire.
- cpu_reset  output  1  reset to the CPU.
- cpu_halt  output  1  freezes the CPU (equals `done`).
- running  output  1  state is RUN.
- done  output  1  a terminal state has been reached.
- status  output  3  0 none, 1 EXIT, 2 HALT_PC, 3 STALL, 4 TIMEOUT.
- exit_code  output  8  exit value.
- cycle_count  output  CNT_WIDTH  RUN cycles elapsed.
- retire_count  output  CNT_WIDTH  instructions retired.

## Operation
- States: HOLD, RUN, DONE. DONE is qualified by `status`.
- Async `reset` sets HOLD, `cpu_reset`=1, `cpu_halt`=0, `running`=0, `done`=0, `status`=0, `exit_code`=0, and both counters and the idle counter to 0.
- HOLD: the hold counter counts up to RESET_CYCLES, then the block enters RUN and `cpu_reset` drops. Counters stay at 0.
- RUN:
  - `cycle_count` increments every cycle.
  - `retire_count` increments when `retire_valid`=1.
  - The idle counter clears on a retire and otherwise increments.
- Events, evaluated only in RUN; each requires `retire_valid` unless noted:
  - EXIT: `instr`==32'h0000_000C and `reg_v0`==10 (`exit_code`=0), or `reg_v0`==17 (`exit_code`=`reg_a0[7:0]`). A syscall with any other $v0 is ignored.
  - HALT_PC: HALT_PC_EN=1 and `pc`==HALT_PC.
  - STALL (no `retire_valid` needed): the idle counter would reach STALL_LIMIT.
  - TIMEOUT (no `retire_valid` needed): `cycle_count` would reach MAX_CYCLES.
- Simultaneous events resolve by priority EXIT > HALT_PC > STALL > TIMEOUT. Exactly one status is latched.
- DONE is sticky. Counters freeze, `cpu_reset` stays 0, and `retire_valid` is ignored. Only `reset` or `restart` leave DONE.
- `restart` from any state:
  - Next edge: HOLD, `cpu_reset`=1.
  - Counters, `status` and `exit_code` clear.
  - `restart` takes priority over any event in the same cycle.
- Counters saturate at all-ones and never wrap.

## Timing
- Every output is registered. Events take effect at the edge that ends the event cycle and are visible in the following cycle.
- With RESET_CYCLES=N, `cpu_reset` is 1 for exactly N full cycles after `reset` falls (synchronised to clk), then 0. The first RUN cycle is the first cycle with `cpu_reset`=0.
- The event cycle is itself counted:
  - `cycle_count` and `retire_count` include the retiring syscall or halt instruction.
  - On TIMEOUT, `cycle_count`==MAX_CYCLES.
  - On STALL, the idle counter equals STALL_LIMIT.
- `running` and `done` are never both 1.
- Async `reset` during RUN or DONE clears all state immediately, with no clock edge required.

## Test plan
- Reset pulse, RESET_CYCLES=2: release `reset` → `cpu_reset`=1 for 2 cycles, then 0 with `running`=1. All counters are 0 at the first RUN cycle.
- Exit with code, MAX_CYCLES=1000:
  - Stimulus: retire 5 instrs at 1/cycle, then syscall with v0=17, a0=0x12345642.
  - Next cycle: `done`=1, `status`=1, `exit_code`=0x42, `retire_count`=6, `cycle_count`=6, `cpu_halt`=1. Counters are unchanged 10 cycles later.
- Ignored syscall: syscall with v0=1 → stays RUN, `retire_count` increments.
- HALT_PC plus priority:
  - HALT_PC_EN=1, HALT_PC=0x1FFC: syscall (v0=10) retiring at pc 0x1FFC → `status`=1, `exit_code`=0.
  - Non-syscall retire at 0x1FFC → `status`=2.
- Stall vs timeout, STALL_LIMIT=4, MAX_CYCLES=8:
  - 2 retires, then no retires → `status`=3 with `cycle_count`=6.
  - STALL_LIMIT=0 with continuous retires → `status`=4, `cycle_count`=8, `retire_count`=8.
- Restart and async reset:
  - In DONE, pulse `restart` → HOLD with `cpu_reset`=1 for 2 cycles, counters 0, `status`=0.
  - Assert `reset` mid-RUN between clock edges → outputs immediately reach reset values.

Source files
------------

// File: rtl/cpu_run_monitor_if.sv
// Retire-side bus from the single-cycle MIPS CPU to the run monitor.
// Carries one retirement per cycle, qualified by retire_valid.
//   retire_valid : an instruction retires this cycle
//   pc           : PC of the retiring instruction
//   instr        : retiring instruction word
//   reg_v0       : $v0 value read at retire
//   reg_a0       : $a0 value read at retire
// master = CPU writeback/PC path, slave = cpu_run_monitor.
interface cpu_run_monitor_if #(
    parameter int PC_WIDTH = 32
);
    logic                retire_valid;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [31:0]         reg_v0;
    logic [31:0]         reg_a0;

    modport master (
        output retire_valid,
        output pc,
        output instr,
        output reg_v0,
        output reg_a0
    );

    modport slave (
        input retire_valid,
        input pc,
        input instr,
        input reg_v0,
        input reg_a0
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run-control and end-of-program detector for the single-cycle MIPS CPU.
// Generates the CPU reset pulse, counts RUN cycles and retired
// instructions, and stops the run on an exit syscall, a retire at the
// halt PC, a retire-stall watchdog or a cycle-limit timeout.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   restart      : synchronous pulse, re-enters HOLD from any state
//   retire_bus   : retire-side bus (slave modport)
//   cpu_reset    : reset to the CPU
//   cpu_halt     : freezes the CPU (same as done)
//   running      : monitor is in RUN
//   done         : a terminal state has been reached
//   status       : 0 none, 1 EXIT, 2 HALT_PC, 3 STALL, 4 TIMEOUT
//   exit_code    : exit value ($a0[7:0] for exit2, else 0)
//   cycle_count  : RUN cycles elapsed (saturating)
//   retire_count : instructions retired (saturating)
module cpu_run_monitor #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  CNT_WIDTH    = 32,
    parameter int                  RESET_CYCLES = 2,
    parameter int unsigned         MAX_CYCLES   = 1000,
    parameter int unsigned         STALL_LIMIT  = 64,
    parameter logic [PC_WIDTH-1:0] HALT_PC      = 32'h0000_1FFC,
    parameter int                  HALT_PC_EN   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    cpu_run_monitor_if.slave     retire_bus,
    output logic                 cpu_reset,
    output logic                 cpu_halt,
    output logic                 running,
    output logic                 done,
    output logic [2:0]           status,
    output logic [7:0]           exit_code,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retire_count
);
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] STATUS_NONE    = 3'd0;
    localparam logic [2:0] STATUS_EXIT    = 3'd1;
    localparam logic [2:0] STATUS_HALT_PC = 3'd2;
    localparam logic [2:0] STATUS_STALL   = 3'd3;
    localparam logic [2:0] STATUS_TIMEOUT = 3'd4;

    localparam int                  HOLD_W    = $clog2(RESET_CYCLES + 1) + 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESET_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ALL  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MAX_V    = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [CNT_WIDTH-1:0] STALL_V  = CNT_WIDTH'(STALL_LIMIT);

    state_t               state_reg;
    logic [HOLD_W-1:0]    hold_cnt_reg;
    logic [CNT_WIDTH-1:0] idle_cnt_reg;

    logic                 retire_valid;
    logic [PC_WIDTH-1:0]  pc;
    logic [31:0]          instr;
    logic [31:0]          reg_v0;
    logic [31:0]          reg_a0;

    assign retire_valid = retire_bus.retire_valid;
    assign pc           = retire_bus.pc;
    assign instr        = retire_bus.instr;
    assign reg_v0       = retire_bus.reg_v0;
    assign reg_a0       = retire_bus.reg_a0;

    // Only the low byte of $a0 becomes the exit code.
    logic unused_a0_hi;
    assign unused_a0_hi = &{1'b0, reg_a0[31:8]};

    logic [CNT_WIDTH-1:0] cycle_next;
    logic [CNT_WIDTH-1:0] retire_next;
    logic [CNT_WIDTH-1:0] idle_next;
    logic                 exit_hit;
    logic                 halt_hit;
    logic                 stall_hit;
    logic                 timeout_hit;
    logic [7:0]           exit_val;

    // Candidate counter values for the current RUN cycle. Events compare
    // against these so the event cycle is itself counted.
    always_comb begin
        cycle_next  = cycle_count;
        retire_next = retire_count;
        idle_next   = idle_cnt_reg;
        if (cycle_count != CNT_ALL) begin
            cycle_next = cycle_count + CNT_ONE;
        end
        if (retire_valid) begin
            idle_next = '0;
            if (retire_count != CNT_ALL) begin
                retire_next = retire_count + CNT_ONE;
            end
        end else if (idle_cnt_reg != CNT_ALL) begin
            idle_next = idle_cnt_reg + CNT_ONE;
        end
    end

    always_comb begin
        exit_hit    = retire_valid && (instr == 32'h0000_000C) &&
                      ((reg_v0 == 32'd10) || (reg_v0 == 32'd17));
        exit_val    = (reg_v0 == 32'd17) ? reg_a0[7:0] : 8'd0;
        halt_hit    = (HALT_PC_EN != 0) && retire_valid && (pc == HALT_PC);
        stall_hit   = (STALL_LIMIT != 0) && !retire_valid && (idle_next == STALL_V);
        timeout_hit = (MAX_CYCLES != 0) && (cycle_next == MAX_V);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            cpu_reset    <= 1'b1;
            cpu_halt     <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            status       <= STATUS_NONE;
            exit_code    <= 8'd0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else if (restart) begin
            state_reg    <= ST_HOLD;
            // The restart edge itself begins the first full held cycle,
            // whereas after reset release the first edge only synchronises.
            // Starting one step ahead keeps both paths at RESET_CYCLES
            // full cycles of cpu_reset.
            hold_cnt_reg <= HOLD_W'(1);
            idle_cnt_reg <= '0;
            cpu_reset    <= 1'b1;
            cpu_halt     <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            status       <= STATUS_NONE;
            exit_code    <= 8'd0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg <= ST_RUN;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    cycle_count  <= cycle_next;
                    retire_count <= retire_next;
                    idle_cnt_reg <= idle_next;
                    if (exit_hit || halt_hit || stall_hit || timeout_hit) begin
                        state_reg <= ST_DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        cpu_halt  <= 1'b1;
                        // Priority: EXIT > HALT_PC > STALL > TIMEOUT
                        if (exit_hit) begin
                            status    <= STATUS_EXIT;
                            exit_code <= exit_val;
                        end else if (halt_hit) begin
                            status <= STATUS_HALT_PC;
                        end else if (stall_hit) begin
                            status <= STATUS_STALL;
                        end else begin
                            status <= STATUS_TIMEOUT;
                        end
                    end
                end
                ST_DONE: begin
                    // Sticky: only reset or restart leave DONE.
                end
                default: begin
                    state_reg <= ST_HOLD;
                    cpu_reset <= 1'b1;
                    running   <= 1'b0;
                    done      <= 1'b0;
                    cpu_halt  <= 1'b0;
                end
            endcase
        end
    end
endmodule
